score_display_bcd: RTL and testbench
====================================

// Module: score_display_bcd
// PURPOSE
//  Parametrised successor score renderer: converts a binary score to NUM_DIGITS decimal digits with a
//  sequential double-dabble engine, then drives the digit-strip ROM address for the VGA pixel stream.
//  Sits between game-state score and the numbers image ROM; the ROM colour is fetched externally.
//  Adds leading-zero suppression, dynamic centring, overflow clamp and tear-free per-frame update.
// PARAMETERS
//  SCREEN_WIDTH   640  visible pixels per line
//  NUM_IMG_WIDTH  342  strip width holding glyphs 0-9; NUM_WIDTH = NUM_IMG_WIDTH/10 (34)
//  NUM_HEIGHT     46   glyph height in lines
//  NUM_DIGITS     4    displayed digit positions (1..8)
//  SCORE_WIDTH    16   binary score width (1..32)
//  LEADING_ZEROS  0    1 = always show NUM_DIGITS digits; 0 = suppress leading zeros (min 1 digit)
// PORTS
//  clk           in   1                     pixel clock
//  resetn        in   1                     synchronous active-low reset
//  frame_start   in   1                     one-cycle pulse at start of vertical blank
//  score         in   SCORE_WIDTH           binary score, sampled on accepted frame_start
//  score_offset  in   9                     top line of the score row
//  x             in   10                    current pixel column
//  y             in   9                     current pixel row
//  inside_score  out  1                     registered: pixel lies on a shown glyph
//  img_addr      out  32                    registered: ROM address for current pixel
//  conv_busy     out  1                     conversion in progress
//  digits_valid  out  1                     one-cycle pulse when new digits committed
//  overflow      out  1                     last committed score >= 10^NUM_DIGITS
// BEHAVIOUR
//  Reset (resetn=0 at clk edge): state IDLE, display digits all 0, shown count 1, all outputs 0.
//  FSM IDLE -> LOAD -> SHIFT -> COMMIT -> IDLE.
//   IDLE:   frame_start=1 -> LOAD; shift reg <= score, BCD reg <= 0, overflow_next <= (score >= 10^NUM_DIGITS).
//   SHIFT:  exactly SCORE_WIDTH cycles; each cycle add 3 to every BCD nibble >= 5, then shift left 1 with score MSB in.
//   COMMIT: display digits <= BCD (or all 9s if overflow_next); overflow <= overflow_next;
//           shown count <= LEADING_ZEROS ? NUM_DIGITS : max(1, significant digits); digits_valid=1 this cycle.
//  digits_valid asserts SCORE_WIDTH+2 cycles after the frame_start cycle; conv_busy high LOAD..COMMIT inclusive.
//  frame_start while busy: set pending flag; on COMMIT->IDLE with pending, go straight to LOAD (re-sample score), clear pending.
//  Display registers change only in COMMIT; the render path never sees partial BCD.
//  Render (n = shown count, L = (SCREEN_WIDTH - n*NUM_WIDTH)/2, integer divide):
//   in_y = score_offset <= y < score_offset+NUM_HEIGHT (half-open); in_x = L <= x < L + n*NUM_WIDTH.
//   position p = (x-L)/NUM_WIDTH, leftmost p=0 = most significant shown digit; glyph d = that digit.
//   img_addr = d*NUM_WIDTH + (x - L - p*NUM_WIDTH) + NUM_IMG_WIDTH*(y - score_offset).
//   Division by NUM_WIDTH implemented by compare chain against L + k*NUM_WIDTH, no divider.
//  Latency: inside_score and img_addr registered, 1 cycle after x/y; outside region img_addr=0, inside_score=0.
//  Arithmetic: all address math 32-bit unsigned; y - score_offset evaluated only when in_y.
//  Reset mid-conversion: abort to IDLE, display returns to reset values, pending cleared.
// TESTING
//  T1 reset, score=0, pulse frame_start -> digits_valid at +18 cycles; one glyph, inside_score=1 for x 303..336
//     only, y in [score_offset, score_offset+45]; img_addr at (303,score_offset) = 0.
//  T2 score=1234 -> L=252; x=286,y=score_offset -> img_addr=68 one cycle later; x=251 and x=388 -> inside_score=0.
//  T3 score=10000 (NUM_DIGITS=4) -> overflow=1, displayed 9999; next frame score=7 -> overflow=0, single glyph '7'.
//  T4 frame_start at +5 cycles into conversion with score changed 42->43 -> first commit shows 42, second
//     conversion starts immediately, commit shows 43; no third conversion.
//  T5 resetn=0 at SHIFT cycle 7 -> conv_busy=0 next cycle, no digits_valid, display back to single '0'.
//  T6 LEADING_ZEROS=1, score=5 -> four glyphs 0,0,0,5 from x=252 to x=387; exhaustive frame scan vs reference model.

Source files
------------

// File: rtl/score_display_bcd.sv
// ---------------------------------------------------------------------------
// score_display_bcd
//   Converts a binary score into NUM_DIGITS decimal digits using a sequential
//   double-dabble engine. It then produces the digit-strip ROM address for each
//   pixel of the VGA stream. The score is sampled once per frame, and the
//   display registers change only on commit, so the picture never tears.
//   Leading zeros can be suppressed. The score row is centred on the line.
//   A score at or above 10^NUM_DIGITS is clamped to all nines.
//
// Ports
//   clk           pixel clock
//   resetn        synchronous active-low reset
//   frame_start   one-cycle pulse at start of vertical blank
//   score         binary score, sampled when a conversion is accepted
//   score_offset  top line of the score row
//   x, y          current pixel column / row
//   inside_score  registered: pixel lies on a shown glyph
//   img_addr      registered: ROM address for the current pixel (0 outside)
//   conv_busy     conversion in progress (LOAD..COMMIT)
//   digits_valid  one-cycle pulse in the COMMIT cycle
//   overflow      last committed score was >= 10^NUM_DIGITS
// ---------------------------------------------------------------------------
module score_display_bcd #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int NUM_IMG_WIDTH = 342,
  parameter int NUM_HEIGHT    = 46,
  parameter int NUM_DIGITS    = 4,
  parameter int SCORE_WIDTH   = 16,
  parameter int LEADING_ZEROS = 0
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   frame_start,
  input  logic [SCORE_WIDTH-1:0] score,
  input  logic [8:0]             score_offset,
  input  logic [9:0]             x,
  input  logic [8:0]             y,
  output logic                   inside_score,
  output logic [31:0]            img_addr,
  output logic                   conv_busy,
  output logic                   digits_valid,
  output logic                   overflow
);

  localparam int NUM_WIDTH = NUM_IMG_WIDTH / 10;
  localparam int BCD_W     = 4 * NUM_DIGITS;
  localparam int CNT_W     = $clog2(SCORE_WIDTH + 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] all_nines();
    logic [BCD_W-1:0] r;
    for (int i = 0; i < NUM_DIGITS; i++) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  // One double-dabble step: correct every nibble >= 5, then shift in the next bit.
  // Nibbles above NUM_DIGITS are dropped. A correction only carries upward,
  // so the lower digits stay exact.
  function automatic logic [BCD_W-1:0] dabble_shift(input logic [BCD_W-1:0] b,
                                                    input logic bit_in);
    logic [BCD_W-1:0] t;
    t = b;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    return {t[BCD_W-2:0], bit_in};
  endfunction

  // Number of significant digits, never less than one.
  function automatic logic [3:0] sig_digits(input logic [BCD_W-1:0] b);
    logic [3:0] n;
    n = 4'd1;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (b[4*i +: 4] != 4'd0) n = 4'(i + 1);
    return n;
  endfunction

  localparam logic [63:0]      LIMIT = pow10(NUM_DIGITS);
  localparam logic [BCD_W-1:0] NINES = all_nines();

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, COMMIT} state_t;

  state_t                 state_q;
  logic [SCORE_WIDTH-1:0] shift_q;
  logic [BCD_W-1:0]       bcd_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   ovf_next_q;
  logic                   pending_q;
  logic [BCD_W-1:0]       disp_q;
  logic [3:0]             shown_q;
  logic                   overflow_q;
  logic                   busy_q;
  logic                   valid_q;
  logic                   inside_q;
  logic [31:0]            addr_q;

  logic                   score_ovf_d;
  logic [BCD_W-1:0]       bcd_d;
  logic [BCD_W-1:0]       commit_d;
  logic [3:0]             shown_d;

  always_comb begin
    score_ovf_d = {{(64-SCORE_WIDTH){1'b0}}, score} >= LIMIT;
    bcd_d       = dabble_shift(bcd_q, shift_q[SCORE_WIDTH-1]);
    commit_d    = ovf_next_q ? NINES : bcd_q;
    shown_d     = (LEADING_ZEROS != 0) ? 4'(NUM_DIGITS) : sig_digits(commit_d);
  end

  // Conversion FSM. Every output it drives is a register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      pending_q  <= 1'b0;
      disp_q     <= '0;
      shown_q    <= 4'd1;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            shift_q    <= score;
            bcd_q      <= '0;
            ovf_next_q <= score_ovf_d;
          end
        end
        LOAD: begin
          state_q <= SHIFT;
          cnt_q   <= '0;
          if (frame_start) pending_q <= 1'b1;
        end
        SHIFT: begin
          bcd_q   <= bcd_d;
          shift_q <= shift_q << 1;
          if (frame_start) pending_q <= 1'b1;
          if (cnt_q == CNT_W'(SCORE_WIDTH - 1)) begin
            state_q <= COMMIT;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        COMMIT: begin
          disp_q     <= commit_d;
          overflow_q <= ovf_next_q;
          shown_q    <= shown_d;
          // A frame_start seen during the conversion (or in this cycle) restarts at once.
          if (pending_q || frame_start) begin
            state_q    <= LOAD;
            pending_q  <= 1'b0;
            shift_q    <= score;
            bcd_q      <= '0;
            ovf_next_q <= score_ovf_d;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Render path: it works only from the committed display registers.
  logic [31:0] n32, span, left, x32, y32, off32, base, row;
  logic [3:0]  pos, idx, glyph;
  logic        in_x, in_y, inside_d;
  logic [31:0] addr_d;

  always_comb begin
    n32   = 32'(shown_q);
    span  = n32 * 32'(NUM_WIDTH);
    left  = (32'(SCREEN_WIDTH) - span) >> 1;
    x32   = 32'(x);
    y32   = 32'(y);
    off32 = 32'(score_offset);
    in_y  = (y32 >= off32) && (y32 < off32 + 32'(NUM_HEIGHT));
    in_x  = (x32 >= left) && (x32 < left + span);
    // Find the glyph position with a compare chain instead of a divider.
    pos   = 4'd0;
    base  = left;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if ((32'(k) < n32) && (x32 >= left + 32'(k * NUM_WIDTH))) begin
        pos  = 4'(k);
        base = left + 32'(k * NUM_WIDTH);
      end
    end
    idx      = shown_q - 4'd1 - pos;
    glyph    = disp_q[{idx, 2'b00} +: 4];
    row      = in_y ? (y32 - off32) : 32'd0;
    inside_d = in_x && in_y;
    addr_d   = inside_d ? (32'(glyph) * 32'(NUM_WIDTH) + (x32 - base) +
                           32'(NUM_IMG_WIDTH) * row) : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      inside_q <= 1'b0;
      addr_q   <= 32'd0;
    end else begin
      inside_q <= inside_d;
      addr_q   <= addr_d;
    end
  end

  assign inside_score = inside_q;
  assign img_addr     = addr_q;
  assign conv_busy    = busy_q;
  assign digits_valid = valid_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_score_display_bcd.sv
module tb_score_display_bcd;

  logic        clk = 1'b0;
  logic        resetn;

  // Instance A: leading zeros suppressed, score row at line 100
  logic        fs_a;
  logic [15:0] score_a;
  logic [8:0]  off_a;
  logic [9:0]  x_a;
  logic [8:0]  y_a;
  logic        in_a, busy_a, dv_a, ovf_a;
  logic [31:0] addr_a;

  // Instance B: leading zeros shown, score row at line 50
  logic        fs_b;
  logic [15:0] score_b;
  logic [8:0]  off_b;
  logic [9:0]  x_b;
  logic [8:0]  y_b;
  logic        in_b, busy_b, dv_b, ovf_b;
  logic [31:0] addr_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  score_display_bcd #(.LEADING_ZEROS(0)) u_dut (
    .clk(clk), .resetn(resetn), .frame_start(fs_a), .score(score_a),
    .score_offset(off_a), .x(x_a), .y(y_a), .inside_score(in_a),
    .img_addr(addr_a), .conv_busy(busy_a), .digits_valid(dv_a), .overflow(ovf_a));

  score_display_bcd #(.LEADING_ZEROS(1)) u_lz (
    .clk(clk), .resetn(resetn), .frame_start(fs_b), .score(score_b),
    .score_offset(off_b), .x(x_b), .y(y_b), .inside_score(in_b),
    .img_addr(addr_b), .conv_busy(busy_b), .digits_valid(dv_b), .overflow(ovf_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Start a conversion on one instance and measure cycles until digits_valid.
  // The bench returns one cycle after the pulse, so the commit is visible.
  task automatic convert(input bit sel, input logic [15:0] s, input string tag);
    int lat;
    bit got_dv;
    lat = 0;
    @(negedge clk);
    if (sel) begin score_b = s; fs_b = 1'b1; end
    else     begin score_a = s; fs_a = 1'b1; end
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) begin fs_a = 1'b0; fs_b = 1'b0; end
      got_dv = sel ? dv_b : dv_a;
      if (got_dv) begin lat = i; break; end
    end
    check({tag, " latency"}, lat, 18);
    @(negedge clk);
  endtask

  // Present one pixel to instance A and wait for its registered result.
  task automatic probe_a(input int px, input int py);
    x_a = 10'(px);
    y_a = 9'(py);
    @(negedge clk);
  endtask

  task automatic probe_b(input int px, input int py);
    x_b = 10'(px);
    y_b = 9'(py);
    @(negedge clk);
  endtask

  // Reference model for instance B (NUM_DIGITS digits always shown)
  int ref_dig[4];
  task automatic model_b(input int px, input int py, output int e_in, output int e_addr);
    int n, lft, p;
    n   = 4;
    lft = (640 - n * 34) / 2;
    e_in = 0;
    e_addr = 0;
    if (py >= 50 && py < 96 && px >= lft && px < lft + n * 34) begin
      p      = (px - lft) / 34;
      e_in   = 1;
      e_addr = ref_dig[n - 1 - p] * 34 + (px - lft) % 34 + 342 * (py - 50);
    end
  endtask

  initial begin
    int pulses, first_t, second_t, e_in, e_addr;
    resetn = 1'b0;
    fs_a = 1'b0; score_a = '0; off_a = 9'd100; x_a = '0; y_a = '0;
    fs_b = 1'b0; score_b = '0; off_b = 9'd50;  x_b = '0; y_b = '0;
    repeat (3) @(negedge clk);
    check("rst inside", 32'(in_a), 0);
    check("rst addr", addr_a, 0);
    check("rst busy", 32'(busy_a), 0);
    check("rst valid", 32'(dv_a), 0);
    check("rst ovf", 32'(ovf_a), 0);
    resetn = 1'b1;
    @(negedge clk);

    // T1: score 0, a single centred glyph at x 303..336
    convert(1'b0, 16'd0, "t1");
    probe_a(302, 100); check("t1 x302 in", 32'(in_a), 0);
    probe_a(303, 100); check("t1 x303 in", 32'(in_a), 1);
    check("t1 x303 addr", addr_a, 0);
    probe_a(336, 101); check("t1 x336 in", 32'(in_a), 1);
    check("t1 x336 addr", addr_a, 375);
    probe_a(337, 100); check("t1 x337 in", 32'(in_a), 0);
    probe_a(303, 99);  check("t1 y99 in", 32'(in_a), 0);
    probe_a(303, 145); check("t1 y145 in", 32'(in_a), 1);
    probe_a(303, 146); check("t1 y146 in", 32'(in_a), 0);
    check("t1 y146 addr", addr_a, 0);

    // T2: score 1234, L = 252
    convert(1'b0, 16'd1234, "t2");
    probe_a(286, 100); check("t2 x286 addr", addr_a, 68);
    probe_a(251, 100); check("t2 x251 in", 32'(in_a), 0);
    probe_a(388, 100); check("t2 x388 in", 32'(in_a), 0);
    probe_a(387, 101); check("t2 x387 in", 32'(in_a), 1);
    check("t2 x387 addr", addr_a, 511);
    probe_a(252, 100); check("t2 x252 addr", addr_a, 34);
    check("t2 ovf", 32'(ovf_a), 0);

    // T3: overflow clamp, then recovery
    convert(1'b0, 16'd10000, "t3a");
    check("t3 ovf set", 32'(ovf_a), 1);
    probe_a(252, 100); check("t3 x252 addr", addr_a, 306);
    probe_a(387, 100); check("t3 x387 addr", addr_a, 339);
    convert(1'b0, 16'd7, "t3b");
    check("t3 ovf clr", 32'(ovf_a), 0);
    probe_a(303, 100); check("t3 x303 addr", addr_a, 238);
    probe_a(302, 100); check("t3 x302 in", 32'(in_a), 0);

    // T4: frame_start during conversion is queued; the score changes 42 -> 43
    x_a = 10'd320; y_a = 9'd100;
    pulses = 0; first_t = 0; second_t = 0;
    @(negedge clk);
    score_a = 16'd42; fs_a = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      @(negedge clk);
      if (i == 1) fs_a = 1'b0;
      if (i == 5) begin fs_a = 1'b1; score_a = 16'd43; end
      if (i == 6) fs_a = 1'b0;
      if (dv_a) begin
        pulses++;
        if (pulses == 1) first_t = i;
        if (pulses == 2) second_t = i;
      end
      if (i == 19) check("t4 busy restart", 32'(busy_a), 1);
      if (i == 25) check("t4 first commit", addr_a, 68);
      if (i == 37) check("t4 busy done", 32'(busy_a), 0);
      if (i == 45) check("t4 second commit", addr_a, 102);
    end
    check("t4 pulses", pulses, 2);
    check("t4 first t", first_t, 18);
    check("t4 second t", second_t, 36);

    // T5: reset in the middle of SHIFT
    pulses = 0;
    @(negedge clk);
    score_a = 16'd55; fs_a = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 1) fs_a = 1'b0;
    end
    check("t5 busy before", 32'(busy_a), 1);
    resetn = 1'b0;
    @(negedge clk);
    check("t5 busy", 32'(busy_a), 0);
    resetn = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dv_a) pulses++;
    end
    check("t5 no valid", pulses, 0);
    probe_a(303, 100); check("t5 x303 in", 32'(in_a), 1);
    check("t5 x303 addr", addr_a, 0);
    probe_a(302, 100); check("t5 x302 in", 32'(in_a), 0);

    // T6: leading zeros shown, score 5 -> glyphs 0,0,0,5
    convert(1'b1, 16'd5, "t6");
    ref_dig[0] = 5; ref_dig[1] = 0; ref_dig[2] = 0; ref_dig[3] = 0;
    probe_b(252, 50); check("t6 x252 in", 32'(in_b), 1);
    check("t6 x252 addr", addr_b, 0);
    probe_b(387, 50); check("t6 x387 addr", addr_b, 203);
    probe_b(251, 50); check("t6 x251 in", 32'(in_b), 0);
    for (int py = 49; py <= 96; py++) begin
      for (int px = 240; px <= 400; px++) begin
        probe_b(px, py);
        model_b(px, py, e_in, e_addr);
        check($sformatf("t6 scan in %0d,%0d", px, py), 32'(in_b), 32'(e_in));
        check($sformatf("t6 scan addr %0d,%0d", px, py), addr_b, 32'(e_addr));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
